// File: rtl/cohort_dbg_pkg.sv
// cohort_dbg_pkg: shared types, constants and helpers for the Cohort debug readout controller
// Contents: dbg_state_e FSM encoding, DBG_W word width, idx_in_range() bounds check.
package cohort_dbg_pkg;

    localparam int DBG_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        DUMP
    } dbg_state_e;

    function automatic logic idx_in_range(input logic [31:0] idx, input logic [31:0] n);
        return idx < n;
    endfunction

endpackage

// File: rtl/cohort_dbg_if.sv
// cohort_dbg_if: bundle of RegNum live 32-bit debug words from the Cohort engine
// Parameters: RegNum - number of debug words.
// Modports:   master drives dbg_data, slave observes it.
interface cohort_dbg_if #(
    parameter int RegNum = 1
);

    logic [31:0] dbg_data [RegNum];

    modport master (output dbg_data);
    modport slave  (input  dbg_data);

endinterface

// File: rtl/cohort_dbg_rd_port.sv
// cohort_dbg_rd_port: single-entry random-access read request/response stage over the src word array
// Ports: clk, rst (async, active-high); src[RegNum] data source;
//        req_valid/req_ready/req_idx request side; resp_valid/resp_ready/resp_data/resp_err response side.
module cohort_dbg_rd_port
    import cohort_dbg_pkg::*;
#(
    parameter int RegNum = 1,
    parameter int IdxW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DBG_W-1:0] src [RegNum],
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IdxW-1:0]  req_idx,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DBG_W-1:0] resp_data,
    output logic             resp_err
);

    localparam int CW = RegNum > 1 ? $clog2(RegNum) : 1;

    logic             accept;
    logic             hit;
    logic [DBG_W-1:0] rd_word;

    // The response register may be refilled in the same cycle it drains.
    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;
    assign hit       = idx_in_range(32'(req_idx), 32'(RegNum));
    assign rd_word   = hit ? src[req_idx[CW-1:0]] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_data  <= rd_word;
            resp_err   <= !hit;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cohort_dbg_ctrl.sv
// cohort_dbg_ctrl: debug readout controller - snapshot capture, random-access reads and sequential dump
// Ports: clk, rst (async, active-high); dbg (cohort_dbg_if.slave, live words);
//        snap_req/snap_done snapshot control; req_*/resp_* read port; dump_start/dump_* dump stream; busy.
// Build option: define COHORT_DBG_SNAPSHOT_EN to instantiate the shadow array; otherwise reads and
//        dumps sample live data and the snapshot capture is a timing-only no-op.
module cohort_dbg_ctrl
    import cohort_dbg_pkg::*;
#(
    parameter int RegNum = 1,
    parameter int IdxW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    cohort_dbg_if.slave      dbg,
    input  logic             snap_req,
    output logic             snap_done,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IdxW-1:0]  req_idx,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DBG_W-1:0] resp_data,
    output logic             resp_err,
    input  logic             dump_start,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [DBG_W-1:0] dump_data,
    output logic             dump_last,
    output logic             busy
);

    localparam int CW = RegNum > 1 ? $clog2(RegNum) : 1;
    localparam logic [CW-1:0] LAST = CW'(RegNum - 1);

    dbg_state_e       state, state_d;
    logic             snap_pend, dump_pend;
    logic             enter_snap, enter_dump;
    logic             beat, last;
    logic [CW-1:0]    cnt;
    logic [DBG_W-1:0] src [RegNum];

`ifdef COHORT_DBG_SNAPSHOT_EN
    logic [DBG_W-1:0] shadow [RegNum];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RegNum; i++) shadow[i] <= '0;
        end else if (enter_snap) begin
            for (int i = 0; i < RegNum; i++) shadow[i] <= dbg.dbg_data[i];
        end
    end

    always_comb begin
        for (int i = 0; i < RegNum; i++) src[i] = shadow[i];
    end
`else
    // No shadow storage: the SNAP state still runs so software sequencing is identical.
    always_comb begin
        for (int i = 0; i < RegNum; i++) src[i] = dbg.dbg_data[i];
    end
`endif

    assign last = cnt == LAST;
    assign beat = dump_valid && dump_ready;

    // Raw request pulses are considered alongside the pending flags so an idle
    // controller reacts on the very next edge.
    always_comb begin
        state_d = state;
        if (state == IDLE)
            state_d = (snap_pend || snap_req) ? SNAP : (dump_pend || dump_start) ? DUMP : IDLE;
        else if (state == SNAP)
            state_d = IDLE;
        else if (beat && last)
            state_d = IDLE;
        enter_snap = state == IDLE && state_d == SNAP;
        enter_dump = state == IDLE && state_d == DUMP;
        snap_done  = state == SNAP;
        dump_valid = state == DUMP;
        dump_data  = dump_valid ? src[cnt] : '0;
        dump_last  = dump_valid && last;
        busy       = state != IDLE || snap_pend || dump_pend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snap_pend <= 1'b0;
            dump_pend <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            snap_pend <= (snap_pend || snap_req) && !enter_snap;
            // A start while a dump is running is dropped rather than queued.
            dump_pend <= (dump_pend || (dump_start && state != DUMP)) && !enter_dump;
            if (enter_dump)
                cnt <= '0;
            else if (beat)
                cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    cohort_dbg_rd_port #(
        .RegNum (RegNum),
        .IdxW   (IdxW)
    ) u_rd_port (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idx    (req_idx),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

endmodule

// File: tb/tb_cohort_dbg_ctrl.sv
// tb_cohort_dbg_ctrl: self-checking bench for cohort_dbg_ctrl with RegNum=4
module tb_cohort_dbg_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snap_req = 1'b0, snap_done;
    logic        req_valid = 1'b0, req_ready;
    logic [7:0]  req_idx = '0;
    logic        resp_valid, resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        dump_start = 1'b0, dump_valid, dump_ready = 1'b0;
    logic [31:0] dump_data;
    logic        dump_last, busy;

    logic [31:0] live     [N];
    logic [31:0] shadow_m [N];
    logic [32:0] rq [$];
    logic [31:0] dq [$];
    int          n_chk = 0;
    int          n_fail = 0;

    cohort_dbg_if #(.RegNum(N)) dif ();

    always_comb begin
        for (int i = 0; i < N; i++) dif.dbg_data[i] = live[i];
    end

    cohort_dbg_ctrl #(.RegNum(N), .IdxW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .dbg        (dif),
        .snap_req   (snap_req),
        .snap_done  (snap_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idx    (req_idx),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mval(input int i);
`ifdef COHORT_DBG_SNAPSHOT_EN
        return shadow_m[i];
`else
        return live[i];
`endif
    endfunction

    function automatic logic [32:0] exp_rd(input int idx);
        return idx < N ? {1'b0, mval(idx)} : {1'b1, 32'h0};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic capture_model;
        for (int i = 0; i < N; i++) shadow_m[i] = live[i];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        n_chk++;
        if ({snap_done, resp_valid, resp_err, dump_valid, dump_last, busy, req_ready} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000001", {snap_done, resp_valid, resp_err, dump_valid, dump_last, busy, req_ready});
        end
        n_chk++;
        if ({resp_data, dump_data} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got resp %h dump %h want 0", resp_data, dump_data);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) shadow_m[i] = '0;
    endtask

    task automatic test_snapshot;
        live[0] = 32'hAAAA_0000;
        step();
        snap_req = 1'b1;
        capture_model();
        @(negedge clk);
        n_chk++;
        if (snap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL snap_done_early: got %b want 0", snap_done);
        end
        step();
        snap_req  = 1'b0;
        live[0]   = 32'h5555_FFFF;
        req_valid = 1'b1;
        req_idx   = 8'd0;
        rq.push_back(exp_rd(0));
        @(negedge clk);
        n_chk++;
        if (snap_done !== 1'b1) begin
            n_fail++;
            $display("FAIL snap_done_next: got %b want 1", snap_done);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (snap_done !== 1'b0) begin
            n_fail++;
            $display("FAIL snap_done_width: got %b want 0", snap_done);
        end
        n_chk++;
        begin
            logic [33:0] exp = {1'b1, rq.pop_front()};
            if ({resp_valid, resp_err, resp_data} !== exp) begin
                n_fail++;
                $display("FAIL snap_read: got %h want %h", {resp_valid, resp_err, resp_data}, exp);
            end
        end
    endtask

    task automatic test_out_of_range;
        int idxs [3] = '{4, 3, 255};
        step();
        for (int k = 0; k <= 3; k++) begin
            if (k < 3) begin
                req_valid = 1'b1;
                req_idx   = 8'(idxs[k]);
                rq.push_back(exp_rd(idxs[k]));
            end else begin
                req_valid = 1'b0;
            end
            if (k > 0) begin
                logic [33:0] exp;
                @(negedge clk);
                exp = {1'b1, rq.pop_front()};
                n_chk++;
                if ({resp_valid, resp_err, resp_data} !== exp) begin
                    n_fail++;
                    $display("FAIL range_idx%0d: got %h want %h", idxs[k-1], {resp_valid, resp_err, resp_data}, exp);
                end
            end
            step();
        end
    endtask

    task automatic test_dump_backpressure;
        int   beats = 0;
        logic [31:0] w;
        for (int i = 0; i < N; i++) dq.push_back(mval(i));
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int k = 0; k < 40 && beats < N; k++) begin
            dump_ready = k[0];
            @(negedge clk);
            w = dq[0];
            n_chk++;
            if ({dump_valid, dump_data, dump_last} !== {1'b1, w, beats == N - 1}) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got v%b d%h l%b want v1 d%h l%b", beats, dump_valid, dump_data, dump_last, w, beats == N - 1);
            end
            if (dump_ready) begin
                void'(dq.pop_front());
                beats++;
            end
            step();
        end
        dump_ready = 1'b0;
        n_chk++;
        if (beats != N) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats want %0d", beats, N);
        end
        @(negedge clk);
        n_chk++;
        if ({busy, dump_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_idle: got busy %b valid %b want 0 0", busy, dump_valid);
        end
        dq.delete();
    endtask

    task automatic test_snap_dump;
        int beats = 0;
        bit sent  = 1'b0;
        bit early = 1'b0;
        bit seen  = 1'b0;
        for (int i = 0; i < N; i++) live[i] = 32'h1000_0000 + 32'(i * 32'h0101);
        step();
        snap_req   = 1'b1;
        dump_start = 1'b1;
        capture_model();
        step();
        snap_req   = 1'b0;
        dump_start = 1'b0;
        for (int i = 0; i < N; i++) live[i] = ~live[i];
        for (int i = 0; i < N; i++) dq.push_back(mval(i));
        @(negedge clk);
        n_chk++;
        if ({snap_done, dump_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL sd_snap_first: got snap %b dump %b want 1 0", snap_done, dump_valid);
        end
        dump_ready = 1'b1;
        for (int k = 0; k < 30 && beats < N; k++) begin
            step();
            snap_req = 1'b0;
            if (beats == 1 && !sent) begin
                snap_req = 1'b1;
                sent = 1'b1;
            end
            @(negedge clk);
            if (snap_done) early = 1'b1;
            if (dump_valid) begin
                logic [31:0] w = dq.pop_front();
                n_chk++;
                if ({dump_data, dump_last} !== {w, beats == N - 1}) begin
                    n_fail++;
                    $display("FAIL sd_beat%0d: got d%h l%b want d%h l%b", beats, dump_data, dump_last, w, beats == N - 1);
                end
                beats++;
            end
        end
        n_chk++;
        if (beats != N || early) begin
            n_fail++;
            $display("FAIL sd_dump_intact: got %0d beats early_snap %b want %0d 0", beats, early, N);
        end
        for (int k = 0; k < 4 && !seen; k++) begin
            step();
            snap_req = 1'b0;
            @(negedge clk);
            if (snap_done) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL sd_deferred_snap: got no snap_done want 1");
        end
        capture_model();
        dump_ready = 1'b0;
        dq.delete();
        step();
    endtask

    task automatic test_back_to_back;
        logic [33:0] exp;
        resp_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                req_valid = 1'b1;
                req_idx   = 8'(i % 6);
                rq.push_back(exp_rd(i % 6));
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                n_chk++;
                if (req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready);
                end
            end
            if (i > 0) begin
                exp = {1'b1, rq.pop_front()};
                n_chk++;
                if ({resp_valid, resp_err, resp_data} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_resp%0d: got %h want %h", i - 1, {resp_valid, resp_err, resp_data}, exp);
                end
            end
            step();
        end
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_idx    = 8'd1;
        rq.push_back(exp_rd(1));
        @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ready0: got %b want 1", req_ready);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            req_idx = 8'd2;
            @(negedge clk);
            exp = {1'b1, rq[0]};
            n_chk++;
            if ({req_ready, resp_valid, resp_err, resp_data} !== {1'b0, exp}) begin
                n_fail++;
                $display("FAIL hold_stall%0d: got %h want %h", k, {req_ready, resp_valid, resp_err, resp_data}, {1'b0, exp});
            end
        end
        step();
        resp_ready = 1'b1;
        @(negedge clk);
        exp = {1'b1, rq.pop_front()};
        n_chk++;
        if ({req_ready, resp_valid, resp_err, resp_data} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL hold_release: got %h want %h", {req_ready, resp_valid, resp_err, resp_data}, {1'b1, exp});
        end
        rq.push_back(exp_rd(2));
        step();
        req_valid = 1'b0;
        @(negedge clk);
        exp = {1'b1, rq.pop_front()};
        n_chk++;
        if ({resp_valid, resp_err, resp_data} !== exp) begin
            n_fail++;
            $display("FAIL hold_last: got %h want %h", {resp_valid, resp_err, resp_data}, exp);
        end
        step();
    endtask

    task automatic test_reset_mid_dump;
        logic [31:0] w;
        for (int i = 0; i < N; i++) live[i] = 32'hC0DE_0000 + 32'(i);
        capture_model();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        dump_start = 1'b1;
        dump_ready = 1'b1;
        step();
        dump_start = 1'b0;
        step();
        step();
        @(negedge clk);
        w = mval(2);
        n_chk++;
        if ({dump_valid, dump_data, dump_last} !== {1'b1, w, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_pre_beat2: got v%b d%h l%b want v1 d%h l0", dump_valid, dump_data, dump_last, w);
        end
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({snap_done, resp_valid, resp_err, dump_valid, dump_last, busy, req_ready, resp_data, dump_data} !== {7'b0000001, 64'h0}) begin
            n_fail++;
            $display("FAIL rst_async: got %h want %h", {snap_done, resp_valid, resp_err, dump_valid, dump_last, busy, req_ready, resp_data, dump_data}, {7'b0000001, 64'h0});
        end
        for (int i = 0; i < N; i++) shadow_m[i] = '0;
        step();
        rst = 1'b0;
        step();
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        @(negedge clk);
        w = mval(0);
        n_chk++;
        if ({dump_valid, dump_data, dump_last} !== {1'b1, w, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_restart: got v%b d%h l%b want v1 d%h l0", dump_valid, dump_data, dump_last, w);
        end
        repeat (N + 1) step();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drain: got busy %b want 0", busy);
        end
        dump_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) live[i] = 32'h1111_1111 * 32'(i + 1);
        for (int i = 0; i < N; i++) shadow_m[i] = '0;
        test_reset();
        test_snapshot();
        test_out_of_range();
        test_dump_backpressure();
        test_snap_dump();
        test_back_to_back();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
